mapu_nxn: RTL and testbench

MAPU_NXN -- requirements
Module: mapu_nxn

---
 rtl/mapu_nxn_pkg.sv | 24 ++
 rtl/mapu_nxn_row.sv | 71 +++++++
 rtl/mapu_nxn.sv | 160 ++++++++++++++++
 tb/tb_mapu_nxn.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapu_nxn_pkg.sv
// Shared types for the NxN matrix processing unit: operation encoding and FSM states.
// Saturating arithmetic is enabled by defining MAPU_NXN_SAT_EN.
package mapu_nxn_pkg;

  typedef enum logic [1:0] {
    MAPU_OP_ADD       = 2'd0,
    MAPU_OP_SUB       = 2'd1,
    MAPU_OP_MULT      = 2'd2,
    MAPU_OP_TRANSPOSE = 2'd3
  } mapu_op_e;

  typedef enum logic [1:0] {
    ST_LOAD_A   = 2'd0,
    ST_LOAD_B   = 2'd1,
    ST_COMPUTE  = 2'd2,
    ST_UNLOAD   = 2'd3
  } mapu_state_e;

  // Row counters need at least one bit even for the smallest matrix.
  function automatic int cnt_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/mapu_nxn_row.sv
// One result row of the matrix unit: ADD/SUB/MULT/TRANSPOSE with overflow detection.
// MAPU_NXN_SAT_EN selects clamping of out-of-range elements instead of wrapping.
module mapu_nxn_row
  import mapu_nxn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic [1:0]                    i_op,
  input  logic [DIM*DATA_WIDTH-1:0]     i_a_row,
  input  logic [DIM*DATA_WIDTH-1:0]     i_b_row,
  input  logic [DIM*DIM*DATA_WIDTH-1:0] i_b_all,
  output logic [DIM*DATA_WIDTH-1:0]     o_c_row,
  output logic                          o_ovf
);

  localparam int W     = DATA_WIDTH;
  localparam int ACC_W = 2 * W + $clog2(DIM) + 1;

`ifdef MAPU_NXN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // hi selects the clamp direction: all-ones for overflow, zero for underflow.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] wrapped,
                                         input logic ovf, input logic hi);
    if (SAT && ovf) return {W{hi}};
    return wrapped;
  endfunction

  logic [W:0]       add_w [DIM];
  logic [W:0]       sub_w [DIM];
  logic [ACC_W-1:0] mac_w [DIM];
  logic [DIM-1:0]   ovf_c;

  always_comb begin
    o_c_row = '0;
    ovf_c   = '0;
    for (int c = 0; c < DIM; c++) begin
      add_w[c] = {1'b0, i_a_row[c*W +: W]} + {1'b0, i_b_row[c*W +: W]};
      // Borrow out of the extra top bit marks a negative difference.
      sub_w[c] = {1'b0, i_a_row[c*W +: W]} - {1'b0, i_b_row[c*W +: W]};
      mac_w[c] = '0;
      for (int k = 0; k < DIM; k++) begin
        mac_w[c] = mac_w[c] + ACC_W'(i_a_row[k*W +: W]) * ACC_W'(i_b_all[(k*DIM+c)*W +: W]);
      end
      case (mapu_op_e'(i_op))
        MAPU_OP_ADD: begin
          ovf_c[c]           = add_w[c][W];
          o_c_row[c*W +: W]  = clamp(add_w[c][W-1:0], add_w[c][W], 1'b1);
        end
        MAPU_OP_SUB: begin
          ovf_c[c]           = sub_w[c][W];
          o_c_row[c*W +: W]  = clamp(sub_w[c][W-1:0], sub_w[c][W], 1'b0);
        end
        MAPU_OP_MULT: begin
          ovf_c[c]           = |mac_w[c][ACC_W-1:W];
          o_c_row[c*W +: W]  = clamp(mac_w[c][W-1:0], |mac_w[c][ACC_W-1:W], 1'b1);
        end
        default: begin
          // The top already presents column r of A on the A-row input.
          o_c_row[c*W +: W]  = i_a_row[c*W +: W];
        end
      endcase
    end
    o_ovf = |ovf_c;
  end

endmodule

// File: rtl/mapu_nxn.sv
// NxN matrix processing unit: streams in A (and B) row by row, computes C one row per
// cycle through a shared row engine, then streams C out. Saturation: define MAPU_NXN_SAT_EN.
module mapu_nxn
  import mapu_nxn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_en,
  input  logic [1:0]                i_op,
  input  logic                      i_vld,
  output logic                      o_rdy,
  input  logic [DIM*DATA_WIDTH-1:0] i_row,
  output logic                      o_vld,
  input  logic                      i_rdy,
  output logic [DIM*DATA_WIDTH-1:0] o_row,
  output logic                      o_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int RW = DIM * DATA_WIDTH;
  localparam int CW = cnt_width(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  mapu_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q;
  logic [RW-1:0]   a_q [DIM];
  logic [RW-1:0]   b_q [DIM];
  logic [RW-1:0]   c_q [DIM];
  logic [DIM-1:0]  ovf_q;

  logic            rdy, a_we, b_we, c_we;
  logic [RW-1:0]   a_sel;
  logic [RW-1:0]   c_row;
  logic [DIM*RW-1:0] b_all;
  logic            row_ovf;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    c_we    = 1'b0;
    case (state_q)
      ST_LOAD_A: begin
        // Only the first row of a job waits for enable; later rows always flow.
        rdy = (cnt_q == '0) ? i_en : 1'b1;
        if (i_vld && rdy) begin
          a_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (mapu_op_e'(op_q) == MAPU_OP_TRANSPOSE) ? ST_COMPUTE : ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        rdy = 1'b1;
        if (i_vld) begin
          b_we = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        c_we = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_UNLOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (i_rdy) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    a_sel = a_q[cnt_q];
    if (mapu_op_e'(op_q) == MAPU_OP_TRANSPOSE) begin
      for (int c = 0; c < DIM; c++) begin
        a_sel[c*W +: W] = a_q[c][int'(cnt_q)*W +: W];
      end
    end
    for (int k = 0; k < DIM; k++) begin
      b_all[k*RW +: RW] = b_q[k];
    end
  end

  mapu_nxn_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM        (DIM)
  ) u_row (
    .i_op    (op_q),
    .i_a_row (a_sel),
    .i_b_row (b_q[cnt_q]),
    .i_b_all (b_all),
    .o_c_row (c_row),
    .o_ovf   (row_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (a_we && cnt_q == '0) op_q <= i_op;
    end
  end

  // Operand and result storage is cleared on reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      if (a_we) a_q[cnt_q] <= i_row;
      if (b_we) b_q[cnt_q] <= i_row;
      if (c_we) begin
        c_q[cnt_q]   <= c_row;
        ovf_q[cnt_q] <= row_ovf;
      end
    end
  end

  assign o_rdy = rdy & ~reset;
  assign o_vld = (state_q == ST_UNLOAD);
  assign o_row = o_vld ? c_q[cnt_q] : '0;
  assign o_ovf = o_vld & ovf_q[cnt_q];

endmodule

// File: tb/tb_mapu_nxn.sv
// Scoreboard bench for mapu_nxn: directed and random jobs against a matrix reference model.
module tb_mapu_nxn;
  import mapu_nxn_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int RW = W * N;

`ifdef MAPU_NXN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, i_en, i_vld, i_rdy;
  logic          o_rdy, o_vld, o_ovf;
  logic [1:0]    i_op;
  logic [RW-1:0] i_row, o_row;

  mapu_nxn #(.DATA_WIDTH(W), .DIM(N)) dut (
    .clk   (clk),
    .reset (reset),
    .i_en  (i_en),
    .i_op  (i_op),
    .i_vld (i_vld),
    .o_rdy (o_rdy),
    .i_row (i_row),
    .o_vld (o_vld),
    .i_rdy (i_rdy),
    .o_row (o_row),
    .o_ovf (o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] row;
    logic          ovf;
  } exp_t;

  exp_t          expq[$];
  exp_t          mon_e;
  int            total = 0, bad = 0, cyc = 0, rows_out = 0, vld_rise_cyc = 0;
  logic          prev_vld = 1'b0, prev_hold = 1'b0, hold_ovf = 1'b0;
  logic [RW-1:0] hold_row = '0;
  logic [W-1:0]  A [N][N];
  logic [W-1:0]  B [N][N];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every output transfer and checks hold under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_vld  = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", RW'(o_vld), RW'(1));
        check("hold_row", o_row, hold_row);
        check("hold_ovf", RW'(o_ovf), RW'(hold_ovf));
      end
      if (o_vld && !prev_vld) vld_rise_cyc = cyc;
      if (o_vld && i_rdy) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_row: got %h want no row", o_row);
        end else begin
          mon_e = expq.pop_front();
          check("row", o_row, mon_e.row);
          check("ovf", RW'(o_ovf), RW'(mon_e.ovf));
        end
        rows_out++;
      end
      prev_hold = o_vld && !i_rdy;
      hold_row  = o_row;
      hold_ovf  = o_ovf;
      prev_vld  = o_vld;
    end
  end

  function automatic logic [W-1:0] pat(input int m, input int r, input int c);
    case (m)
      0: return '0;
      1: return W'(1);
      2: return W'(N * r + c);
      3: return (r == c) ? W'(1) : W'(0);
      4: return W'(2);
      5: return W'(3);
      6: return W'(32'h1_0000);
      default: begin
        case ($urandom_range(0, 2))
          0: return W'($urandom);
          1: return W'($urandom_range(0, 9));
          default: return W'(32'hFFFF_FFFF - $urandom_range(0, 9));
        endcase
      end
    endcase
  endfunction

  task automatic set_ab(input int am, input int bm);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = pat(am, r, c);
        B[r][c] = pat(bm, r, c);
      end
  endtask

  // Reference model: matrix arithmetic in wide integers, then wrap or clamp.
  task automatic push_expected(input logic [1:0] op);
    exp_t         e;
    logic [127:0] full;
    logic [W-1:0] v;
    logic         eo;
    for (int r = 0; r < N; r++) begin
      e.row = '0;
      e.ovf = 1'b0;
      for (int c = 0; c < N; c++) begin
        case (op)
          MAPU_OP_ADD: begin
            full = 128'(A[r][c]) + 128'(B[r][c]);
            eo   = full >= (128'(1) << W);
            v    = (SAT && eo) ? '1 : full[W-1:0];
          end
          MAPU_OP_SUB: begin
            eo = A[r][c] < B[r][c];
            v  = (SAT && eo) ? '0 : A[r][c] - B[r][c];
          end
          MAPU_OP_MULT: begin
            full = '0;
            for (int k = 0; k < N; k++) full += 128'(A[r][k]) * 128'(B[k][c]);
            eo = full >= (128'(1) << W);
            v  = (SAT && eo) ? '1 : full[W-1:0];
          end
          default: begin
            eo = 1'b0;
            v  = A[c][r];
          end
        endcase
        e.row[c*W +: W] = v;
        e.ovf = e.ovf | eo;
      end
      expq.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; retries until accepted or the budget runs out.
  task automatic send_row(input logic [RW-1:0] row, output int t_acc);
    int  waited = 0;
    bit  done = 0;
    t_acc = cyc;
    i_vld = 1'b1;
    i_row = row;
    while (!done) begin
      @(negedge clk);
      if (o_rdy) begin
        done  = 1;
        t_acc = cyc;
      end else if (++waited > 50) begin
        total++;
        bad++;
        $display("FAIL load_timeout: got o_rdy=0 for %0d cycles want 1", waited);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0;
    i_row = {4{32'($urandom)}};
  endtask

  task automatic run_job(input logic [1:0] op, input bit gaps, input bit rand_rdy,
                         input bit bp, input bit rst_mid);
    int            base = rows_out;
    int            t_last = 0;
    int            nrows;
    int            stall = 0;
    logic [RW-1:0] row;
    push_expected(op);
    nrows = (op == MAPU_OP_TRANSPOSE) ? N : 2 * N;
    for (int i = 0; i < nrows; i++) begin
      if (gaps && i > 0) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          @(posedge clk);
          #1;
        end
      end
      for (int c = 0; c < N; c++) row[c*W +: W] = (i < N) ? A[i][c] : B[i-N][c];
      i_op = (i == 0) ? op : 2'($urandom);
      i_en = (i == 0) ? 1'b1 : 1'($urandom);
      send_row(row, t_last);
    end
    @(negedge clk);
    check("compute_rdy", RW'(o_rdy), RW'(0));
    check("compute_vld", RW'(o_vld), RW'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 400; k++) begin
      if (rows_out >= base + N) break;
      if (rst_mid && rows_out >= base + 2) break;
      if (bp && rows_out == base + 1 && stall < 3) begin
        i_rdy = 1'b0;
        stall++;
      end else begin
        i_rdy = rand_rdy ? 1'($urandom) : 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (rst_mid) begin
      reset = 1'b1;
      #1;
      check("rst_vld", RW'(o_vld), RW'(0));
      check("rst_row", o_row, '0);
      check("rst_ovf", RW'(o_ovf), RW'(0));
      check("rst_rdy", RW'(o_rdy), RW'(0));
      expq.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      i_en  = 1'b1;
      @(negedge clk);
      check("rdy_after_midreset", RW'(o_rdy), RW'(1));
      @(posedge clk);
      #1;
    end else begin
      check("rows_received", RW'(rows_out - base), RW'(N));
      check("latency", RW'(vld_rise_cyc - t_last), RW'(N + 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    i_en  = 1'b1;
    i_vld = 1'b0;
    i_rdy = 1'b1;
    i_op  = '0;
    i_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vld", RW'(o_vld), RW'(0));
    check("reset_rdy", RW'(o_rdy), RW'(0));
    check("reset_row", o_row, '0);
    check("reset_ovf", RW'(o_ovf), RW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", RW'(o_rdy), RW'(1));
    @(posedge clk);
    #1;

    // A job must not start while disabled.
    i_en  = 1'b0;
    i_vld = 1'b1;
    i_row = {4{32'hDEAD_BEEF}};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("rdy_disabled", RW'(o_rdy), RW'(0));
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0;

    set_ab(1, 2); run_job(MAPU_OP_ADD,       0, 0, 0, 0);
    set_ab(0, 1); run_job(MAPU_OP_SUB,       0, 0, 0, 0);
    set_ab(3, 2); run_job(MAPU_OP_MULT,      0, 0, 0, 0);
    set_ab(4, 5); run_job(MAPU_OP_MULT,      0, 0, 0, 0);
    set_ab(6, 6); run_job(MAPU_OP_MULT,      0, 0, 0, 0);
    set_ab(2, 7); run_job(MAPU_OP_TRANSPOSE, 0, 0, 0, 0);
    set_ab(7, 7); run_job(MAPU_OP_ADD,       0, 0, 1, 0);
    set_ab(7, 7); run_job(MAPU_OP_ADD,       0, 0, 0, 1);
    set_ab(1, 2); run_job(MAPU_OP_ADD,       0, 0, 0, 0);

    for (int j = 0; j < 12; j++) begin
      set_ab(7, 7);
      run_job(2'($urandom), 1, 1, 0, 0);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", RW'(expq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
